triangle_raster_ctrl: RTL and testbench
=======================================

// Module: triangle_raster_ctrl
// PURPOSE
//  Sequencer for triangle coverage: on start, latches 3 vertices and computes their bounding box.
//  Scans the box row-major (x fastest). Each pixel is tested by ONE shared edge-sign unit,
//  time-multiplexed over the 3 edges, and covered pixels stream out on a valid/ready port.
//  Sits between the vertex source and the pixel consumer; it replaces three parallel edge units.
// PARAMETERS
//  COORD_W   12  unsigned width of every coordinate
//  INCLUSIVE  1  1: edge value >= 0 counts as inside (edges included); 0: only > 0
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  start      in   1        begin a triangle; sampled only in IDLE
//  p1x,p1y    in   COORD_W  vertex 1 (latched on accepted start)
//  p2x,p2y    in   COORD_W  vertex 2
//  p3x,p3y    in   COORD_W  vertex 3
//  busy       out  1        high from the cycle after start is accepted through DONE
//  out_valid  out  1        covered pixel available
//  out_ready  in   1        consumer accepts pixel
//  out_x      out  COORD_W  covered pixel x
//  out_y      out  COORD_W  covered pixel y
//  done       out  1        1-cycle pulse when the scan completes
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, out_valid=0, done=0, out_x=out_y=0, all counters 0.
//  Edge function for edge A->B at point T, all coordinates zero-extended then signed:
//    s = (Tx-Bx)*(Ay-By) - (Ax-Bx)*(Ty-By).
//    Differences are COORD_W+1 signed, products 2*COORD_W+2, s is 2*COORD_W+3. No overflow allowed.
//  Edges are evaluated in order 0:(p1->p2), 1:(p2->p3), 2:(p3->p1).
//  A pixel is inside when all three edges pass (s>=0, or s>0 when INCLUSIVE=0).
//  Winding whose interior gives s<0 emits no pixels; no reordering is done.
//  FSM:
//    IDLE : start=1 -> latch vertices -> BBOX.
//    BBOX : 1 cycle; xmin/xmax/ymin/ymax = min/max of the 3 vertices; x=xmin, y=ymin -> EVAL0.
//    EVAL0/1/2 : 1 cycle per edge; the shared unit is driven with edge k; the pass flag is ANDed
//      into an accumulator.
//    End of EVAL2: if inside, load out_x/out_y and go to EMIT.
//      Otherwise ADVANCE in the same cycle -> EVAL0, or -> DONE if this was the last pixel.
//    EMIT : out_valid=1. out_x/out_y and scan counters are stable until out_valid&&out_ready.
//      On the handshake: ADVANCE -> EVAL0, or -> DONE.
//    ADVANCE rule:
//      x<xmax: x=x+1.
//      x==xmax and y<ymax: x=xmin, y=y+1.
//      x==xmax and y==ymax: last pixel.
//      Comparison is done before the increment, so coordinates 2**COORD_W-1 never wrap.
//    DONE : done=1 for exactly 1 cycle, busy=0 on the next cycle -> IDLE.
//  Timing: outside pixel = 3 cycles; inside pixel = 3 cycles + 1 EMIT cycle (with ready=1).
//  start while not IDLE is ignored; vertex input changes after acceptance have no effect.
//  Degenerate (collinear or coincident) vertices: all s on the line are 0 -> those pixels are
//    inside when INCLUSIVE=1.
//  rst mid-scan: next cycle is IDLE with out_valid=0 and busy=0; no pending pixel is emitted;
//    no done pulse.
// TESTING
//  T1: (0,0),(4,0),(0,4), ready=1 -> 15 pixels with x+y<=4 in row-major order,
//      first (0,0), last (0,4); done on cycle 92 after start.
//  T2: (0,0),(0,4),(4,0) (reversed winding) -> 0 pixels; done after 25*3+2 cycles.
//  T3: T1 with out_ready=0 for 5 cycles at the first pixel -> out_valid held;
//      out_x=0, out_y=0 stable; no pixel lost or duplicated.
//  T4: all vertices (4095,4095) -> exactly one pixel (4095,4095), then done; no wrap to 0.
//  T5: rst asserted during the 3rd pixel of T1 -> IDLE next cycle, outputs 0;
//      a new start works normally.
//  T6: (10,10),(30,10),(20,30); start pulsed again mid-scan -> ignored;
//      pixel (15,15) emitted; pixel set matches the software model.

Source files
------------

// File: rtl/triangle_raster_ctrl.sv
// Triangle coverage sequencer: scans the vertex bounding box row-major and tests each pixel
// with one edge-sign unit shared over the three edges; covered pixels leave on valid/ready.
module triangle_raster_ctrl #(
  parameter int unsigned COORD_W   = 12,
  parameter bit          INCLUSIVE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] p1x,
  input  logic [COORD_W-1:0] p1y,
  input  logic [COORD_W-1:0] p2x,
  input  logic [COORD_W-1:0] p2y,
  input  logic [COORD_W-1:0] p3x,
  input  logic [COORD_W-1:0] p3y,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               done
);

  localparam int unsigned DW = COORD_W + 1;
  localparam int unsigned PW = 2 * COORD_W + 2;
  localparam int unsigned SW = 2 * COORD_W + 3;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StBbox,
    StEval0,
    StEval1,
    StEval2,
    StEmit,
    StDone
  } state_t;

  state_t       state_q, state_d;
  coord_t [2:0] vx_q, vx_d, vy_q, vy_d;
  coord_t       xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  coord_t       x_q, x_d, y_q, y_d;
  coord_t       out_x_q, out_x_d, out_y_q, out_y_d;
  logic         acc_q, acc_d;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Edge operand mux: EVAL0 p1->p2, EVAL1 p2->p3, otherwise p3->p1.
  coord_t ax, ay, bx, by;
  always_comb begin
    ax = vx_q[2];
    ay = vy_q[2];
    bx = vx_q[0];
    by = vy_q[0];
    if (state_q == StEval0) begin
      ax = vx_q[0];
      ay = vy_q[0];
      bx = vx_q[1];
      by = vy_q[1];
    end else if (state_q == StEval1) begin
      ax = vx_q[1];
      ay = vy_q[1];
      bx = vx_q[2];
      by = vy_q[2];
    end
  end

  logic signed [DW-1:0] dtx, day, dax, dty;
  logic signed [PW-1:0] prod_a, prod_b;
  logic signed [SW-1:0] s;
  logic                 pass;

  assign dtx    = $signed({1'b0, x_q}) - $signed({1'b0, bx});
  assign day    = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign dax    = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dty    = $signed({1'b0, y_q}) - $signed({1'b0, by});
  assign prod_a = PW'(dtx) * PW'(day);
  assign prod_b = PW'(dax) * PW'(dty);
  assign s      = SW'(prod_a) - SW'(prod_b);
  assign pass   = ~s[SW-1] & (INCLUSIVE | (|s));

  logic x_at_max, last;
  assign x_at_max = (x_q == xmax_q);
  assign last     = x_at_max && (y_q == ymax_q);

  always_comb begin
    state_d = state_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    x_d     = x_q;
    y_d     = y_q;
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    acc_d   = acc_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          vx_d    = {p3x, p2x, p1x};
          vy_d    = {p3y, p2y, p1y};
          state_d = StBbox;
        end
      end
      StBbox: begin
        xmin_d  = min3(vx_q[0], vx_q[1], vx_q[2]);
        xmax_d  = max3(vx_q[0], vx_q[1], vx_q[2]);
        ymin_d  = min3(vy_q[0], vy_q[1], vy_q[2]);
        ymax_d  = max3(vy_q[0], vy_q[1], vy_q[2]);
        x_d     = xmin_d;
        y_d     = ymin_d;
        state_d = StEval0;
      end
      StEval0: begin
        acc_d   = pass;
        state_d = StEval1;
      end
      StEval1: begin
        acc_d   = acc_q & pass;
        state_d = StEval2;
      end
      StEval2, StEmit: begin
        if (state_q == StEval2 && acc_q && pass) begin
          out_x_d = x_q;
          out_y_d = y_q;
          state_d = StEmit;
        end else if (state_q == StEval2 || out_ready) begin
          // Advance the scan; the max test precedes the increment so the top code never wraps.
          if (last) begin
            state_d = StDone;
          end else begin
            state_d = StEval0;
            if (!x_at_max) begin
              x_d = x_q + coord_t'(1);
            end else begin
              x_d = xmin_q;
              y_d = y_q + coord_t'(1);
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vx_q    <= '0;
      vy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      x_q     <= x_d;
      y_q     <= y_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      acc_q   <= acc_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StEmit);
  assign done      = (state_q == StDone);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_triangle_raster_ctrl.sv
// Bench for triangle_raster_ctrl: directed scenarios plus random triangles checked against
// a pixel-list and cycle-count model derived from the edge-function rules.
module tb_triangle_raster_ctrl;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
  logic          busy, out_valid, out_ready, done;
  logic [CW-1:0] out_x, out_y;

  int checks = 0;
  int errors = 0;

  int exp_x[$];
  int exp_y[$];

  always #5 clk = ~clk;

  triangle_raster_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .p1x       (p1x),
    .p1y       (p1y),
    .p2x       (p2x),
    .p2y       (p2y),
    .p3x       (p3x),
    .p3y       (p3y),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint edge_s(input longint ax, input longint ay, input longint bx,
                                    input longint by, input longint tx, input longint ty);
    return (tx - bx) * (ay - by) - (ax - bx) * (ty - by);
  endfunction

  // Fills the expected pixel queues (row-major) and returns the bounding-box pixel count.
  task automatic build_model(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, output int nbox);
    int x0, x1, y0, y1;
    exp_x.delete();
    exp_y.delete();
    x0 = (ax < bx) ? ax : bx;  x0 = (cx < x0) ? cx : x0;
    x1 = (ax > bx) ? ax : bx;  x1 = (cx > x1) ? cx : x1;
    y0 = (ay < by) ? ay : by;  y0 = (cy < y0) ? cy : y0;
    y1 = (ay > by) ? ay : by;  y1 = (cy > y1) ? cy : y1;
    nbox = (x1 - x0 + 1) * (y1 - y0 + 1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        if (edge_s(ax, ay, bx, by, x, y) >= 0 && edge_s(bx, by, cx, cy, x, y) >= 0 &&
            edge_s(cx, cy, ax, ay, x, y) >= 0) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
      end
    end
  endtask

  // mode 0: ready=1; mode 1: random ready; mode 2: ready low for 5 cycles at first pixel.
  task automatic run_tri(input string tag, input int ax, input int ay, input int bx,
                         input int by, input int cx, input int cy, input int mode,
                         input bit restart, output int n_emit, output int done_cyc);
    int  nbox, n_inside, cyc, stalls, hold, budget;
    bit  saw_done, saw_1515, rdy;
    build_model(ax, ay, bx, by, cx, cy, nbox);
    n_inside = exp_x.size();
    budget   = 6 * nbox + 500;
    n_emit   = 0;
    done_cyc = -1;
    stalls   = 0;
    hold     = 0;
    saw_done = 1'b0;
    saw_1515 = 1'b0;
    p1x = CW'(ax); p1y = CW'(ay);
    p2x = CW'(bx); p2y = CW'(by);
    p3x = CW'(cx); p3y = CW'(cy);
    start     = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    // Vertex inputs are scrambled after acceptance; they must not matter.
    p1x = CW'($urandom_range(0, 4095)); p1y = CW'($urandom_range(0, 4095));
    p2x = CW'($urandom_range(0, 4095)); p2y = CW'($urandom_range(0, 4095));
    p3x = CW'($urandom_range(0, 4095)); p3y = CW'($urandom_range(0, 4095));
    cyc = 1;
    while (cyc < budget && !saw_done) begin
      start = restart && (cyc == 20);
      if (done) begin
        saw_done = 1'b1;
        done_cyc = cyc;
        check({tag, " done cycle"}, 64'(cyc), 64'(2 + 3 * nbox + n_inside + stalls));
        check({tag, " pixels missing"}, 64'(exp_x.size()), 64'd0);
      end else begin
        check({tag, " busy"}, 64'(busy), 64'd1);
        if (out_valid) begin
          if (mode == 1)      rdy = 1'($urandom_range(0, 1));
          else if (mode == 2) rdy = (hold >= 5);
          else                rdy = 1'b1;
          if (exp_x.size() == 0) begin
            check({tag, " extra pixel"}, 64'(out_valid), 64'd0);
          end else begin
            check({tag, " out_x"}, 64'(out_x), 64'(exp_x[0]));
            check({tag, " out_y"}, 64'(out_y), 64'(exp_y[0]));
          end
          out_ready = rdy;
          if (rdy) begin
            if (exp_x.size() != 0) begin
              void'(exp_x.pop_front());
              void'(exp_y.pop_front());
            end
            if (out_x == CW'(15) && out_y == CW'(15)) saw_1515 = 1'b1;
            n_emit++;
          end else begin
            stalls++;
            hold++;
          end
        end else begin
          out_ready = 1'b1;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (!saw_done) check({tag, " done timeout"}, 64'(done), 64'd1);
    check({tag, " busy after done"}, 64'(busy), 64'd0);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
    if (restart) check({tag, " pixel 15,15"}, 64'(saw_1515), 64'd1);
  endtask

  initial begin
    int n_emit, done_cyc, ax, ay, bx, by, cx, cy, bxs, bys, n3, guard;

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0;
    step();
    step();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out_x", 64'(out_x), 64'd0);
    check("reset out_y", 64'(out_y), 64'd0);

    // T1
    run_tri("T1", 0, 0, 4, 0, 0, 4, 0, 1'b0, n_emit, done_cyc);
    check("T1 pixel count", 64'(n_emit), 64'd15);
    check("T1 done at 92", 64'(done_cyc), 64'd92);

    // T2: reversed winding
    run_tri("T2", 0, 0, 0, 4, 4, 0, 0, 1'b0, n_emit, done_cyc);
    check("T2 pixel count", 64'(n_emit), 64'd0);
    check("T2 done at 77", 64'(done_cyc), 64'd77);

    // T3: back-pressure on first pixel
    run_tri("T3", 0, 0, 4, 0, 0, 4, 2, 1'b0, n_emit, done_cyc);
    check("T3 pixel count", 64'(n_emit), 64'd15);

    // T4: top-corner degenerate triangle
    run_tri("T4", 4095, 4095, 4095, 4095, 4095, 4095, 0, 1'b0, n_emit, done_cyc);
    check("T4 pixel count", 64'(n_emit), 64'd1);

    // T5: reset while the third pixel of T1 is pending
    p1x = 0; p1y = 0; p2x = 4; p2y = 0; p3x = 0; p3y = 4;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n3 = 0;
    guard = 0;
    while (!(out_valid && n3 == 2) && guard < 200) begin
      if (out_valid) n3++;
      step();
      guard++;
    end
    check("T5 reached third pixel", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("T5 out_valid", 64'(out_valid), 64'd0);
    check("T5 busy", 64'(busy), 64'd0);
    check("T5 out_x", 64'(out_x), 64'd0);
    check("T5 out_y", 64'(out_y), 64'd0);
    for (int i = 0; i < 10; i++) begin
      check("T5 no done", 64'(done | busy), 64'd0);
      step();
    end
    run_tri("T5 restart", 0, 0, 4, 0, 0, 4, 0, 1'b0, n_emit, done_cyc);
    check("T5 restart pixel count", 64'(n_emit), 64'd15);

    // T6: start re-pulsed mid-scan
    run_tri("T6", 10, 10, 30, 10, 20, 30, 0, 1'b1, n_emit, done_cyc);

    // Random small triangles anywhere in the coordinate space, random back-pressure.
    for (int r = 0; r < 8; r++) begin
      bxs = $urandom_range(0, 4080);
      bys = $urandom_range(0, 4080);
      ax = bxs + $urandom_range(0, 15); ay = bys + $urandom_range(0, 15);
      bx = bxs + $urandom_range(0, 15); by = bys + $urandom_range(0, 15);
      cx = bxs + $urandom_range(0, 15); cy = bys + $urandom_range(0, 15);
      if (r % 2 == 0 && edge_s(ax, ay, bx, by, cx, cy) < 0) begin
        int tx, ty;
        tx = bx; ty = by; bx = cx; by = cy; cx = tx; cy = ty;
      end
      run_tri($sformatf("R%0d", r), ax, ay, bx, by, cx, cy, 1, 1'b0, n_emit, done_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
